motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver.sv | 153 +++++++++++++++
 tb/tb_motor_pwm_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// Multi-channel H-bridge PWM driver with per-channel run/brake FSM and dead-time coast.
// A shared prescaler and PWM counter pace all channels; duty is latched once per period.
module motor_pwm_driver #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned PWM_W    = 8,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [N_CH-1:0]         enable,
    input  logic [N_CH-1:0]         reverse,
    input  logic [N_CH*PWM_W-1:0]   duty,
    output logic [N_CH-1:0]         motor_en,
    output logic [N_CH-1:0]         motor_in1,
    output logic [N_CH-1:0]         motor_in2,
    output logic [2*N_CH-1:0]       ch_state
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [PS_W-1:0] PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StBrake = 2'b10
    } ch_state_e;

    // Two-flop synchronisers for the switch inputs
    logic [N_CH-1:0] en_meta_q;
    logic [N_CH-1:0] en_sync_q;
    logic [N_CH-1:0] rev_meta_q;
    logic [N_CH-1:0] rev_sync_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            en_meta_q  <= '0;
            en_sync_q  <= '0;
            rev_meta_q <= '0;
            rev_sync_q <= '0;
        end else begin
            en_meta_q  <= enable;
            en_sync_q  <= en_meta_q;
            rev_meta_q <= reverse;
            rev_sync_q <= rev_meta_q;
        end
    end

    logic [PS_W-1:0]  presc_q;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic             tick;
    logic             wrap;

    assign tick = (presc_q == PS_MAX);
    assign wrap = tick && (pwm_cnt_q == {PWM_W{1'b1}});

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt_q <= '0;
        end else if (tick) begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_e        state_q;
        ch_state_e        state_d;
        logic [DC_W-1:0]  dead_q;
        logic [DC_W-1:0]  dead_d;
        logic             dir_q;
        logic             dir_d;
        logic [PWM_W-1:0] duty_q;
        logic             run;

        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                state_q <= StIdle;
                dead_q  <= '0;
                dir_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dead_q  <= dead_d;
                dir_q   <= dir_d;
            end
        end

        // New duty takes effect only at the start of a PWM period
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                duty_q <= '0;
            end else if (wrap) begin
                duty_q <= duty[i*PWM_W +: PWM_W];
            end
        end

        always_comb begin
            state_d = state_q;
            dead_d  = dead_q;
            dir_d   = dir_q;
            case (state_q)
                StIdle: begin
                    if (en_sync_q[i]) begin
                        state_d = StRun;
                        dir_d   = rev_sync_q[i];
                    end
                end
                StRun: begin
                    if (!en_sync_q[i] || (rev_sync_q[i] != dir_q)) begin
                        state_d = StBrake;
                        dead_d  = DC_LOAD;
                    end
                end
                StBrake: begin
                    // Inputs are only looked at once the interval has fully elapsed
                    if (dead_q == '0) begin
                        if (en_sync_q[i]) begin
                            state_d = StRun;
                            dir_d   = rev_sync_q[i];
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        dead_d = dead_q - DC_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        assign run = (state_q == StRun);

        assign motor_en[i]        = run && (pwm_cnt_q < duty_q);
        assign motor_in1[i]       = run && dir_q;
        assign motor_in2[i]       = run && !dir_q;
        assign ch_state[2*i +: 2] = state_q;
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: expectations queued at stimulus time, popped at sampling.
// Covers reset, start, reverse with dead time, duty update timing, duty extremes and stop in brake.
module tb_motor_pwm_driver;

    localparam int unsigned N_CH     = 2;
    localparam int unsigned PWM_W    = 4;
    localparam int unsigned PRESCALE = 1;
    localparam int unsigned DEAD_CYC = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] enable = '0;
    logic [1:0] reverse = '0;
    logic [7:0] duty   = '0;
    logic [1:0] motor_en;
    logic [1:0] motor_in1;
    logic [1:0] motor_in2;
    logic [3:0] ch_state;

    int n_pass   = 0;
    int n_checks = 0;
    bit mon_on   = 1'b0;

    // Reference PWM count: one count per clock since reset release
    logic [3:0] cnt_m;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];

    motor_pwm_driver #(
        .N_CH     (N_CH),
        .PWM_W    (PWM_W),
        .PRESCALE (PRESCALE),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .enable    (enable),
        .reverse   (reverse),
        .duty      (duty),
        .motor_en  (motor_en),
        .motor_in1 (motor_in1),
        .motor_in2 (motor_in2),
        .ch_state  (ch_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_m <= '0;
        else         cnt_m <= cnt_m + 4'd1;
    end

    always @(negedge clk) begin
        if (mon_on && resetn) begin
            n_checks++;
            assert ((motor_in1 & motor_in2) == 2'b00) n_pass++;
            else $error("FAIL in1_in2_overlap observed=%b expected=00", motor_in1 & motor_in2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic sb_push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t x;
        n_checks++;
        if (sbq.size() == 0) begin
            $error("FAIL sb_empty observed=%0h expected=queued_entry", obs);
            return;
        end
        x = sbq.pop_front();
        assert (obs === x.exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts motor_en high samples over one full period starting at count 0;
    // optionally rewrites channel 0 duty at sample change_at.
    task automatic measure(input int change_at, input logic [3:0] new_duty,
                           output int hi0, output int hi1);
        int guard;
        guard = 0;
        hi0   = 0;
        hi1   = 0;
        while (cnt_m != 4'd0 && guard < 40) begin
            step(1);
            guard++;
        end
        if (cnt_m != 4'd0) begin
            n_checks++;
            $error("FAIL wrap_timeout observed=%0d expected=0", cnt_m);
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (motor_en[0]) hi0++;
            if (motor_en[1]) hi1++;
            if (i == change_at) duty[3:0] = new_duty;
            step(1);
        end
    endtask

    initial begin
        int hi0;
        int hi1;

        // Reset state
        step(3);
        sb_push("rst_en", 0);
        sb_push("rst_in1", 0);
        sb_push("rst_in2", 0);
        sb_push("rst_state", 0);
        check(motor_en);
        check(motor_in1);
        check(motor_in2);
        check(ch_state);
        resetn = 1'b1;
        mon_on = 1'b1;
        step(2);

        // Start: ch0 forward duty 4, ch1 reverse duty 8
        duty    = {4'd8, 4'd4};
        enable  = 2'b11;
        reverse = 2'b10;
        sb_push("start_e1_state", 4'b0000);
        sb_push("start_e2_state", 4'b0000);
        sb_push("start_e3_state", 4'b0101);
        sb_push("start_in1", 2'b10);
        sb_push("start_in2", 2'b01);
        sb_push("start_hi0", 4);
        sb_push("start_hi1", 8);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check(ch_state);
        end
        check(motor_in1);
        check(motor_in2);
        measure(-1, 4'd0, hi0, hi1);
        check(hi0);
        check(hi1);

        // Reverse ch0 while running: 4 clocks of coast, then opposite direction
        reverse[0] = 1'b1;
        sb_push("rev_e1_state", 4'b0101);
        sb_push("rev_e2_state", 4'b0101);
        for (int i = 0; i < 4; i++) begin
            sb_push("rev_brake_state", 4'b0110);
            sb_push("rev_brake_out", 0);
        end
        sb_push("rev_resume_state", 4'b0101);
        sb_push("rev_resume_in", 2'b10);
        sb_push("rev_hi0", 4);
        sb_push("rev_hi1", 8);
        for (int i = 0; i < 2; i++) begin
            step(1);
            check(ch_state);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            check(ch_state);
            check({motor_en[0], motor_in1[0], motor_in2[0]});
        end
        step(1);
        check(ch_state);
        check({motor_in1[0], motor_in2[0]});
        measure(-1, 4'd0, hi0, hi1);
        check(hi0);
        check(hi1);

        // Duty change mid-period applies from the following period
        sb_push("dupd_cur_hi0", 4);
        sb_push("dupd_next_hi0", 12);
        measure(6, 4'd12, hi0, hi1);
        check(hi0);
        measure(-1, 4'd0, hi0, hi1);
        check(hi0);

        // Extremes
        duty[3:0] = 4'd0;
        sb_push("duty0_hi0", 0);
        step(1);
        measure(-1, 4'd0, hi0, hi1);
        check(hi0);
        duty[3:0] = 4'd15;
        sb_push("duty15_hi0", 15);
        step(1);
        measure(-1, 4'd0, hi0, hi1);
        check(hi0);

        // Stop during brake: interval is not cut short or restarted
        reverse[0] = 1'b0;
        sb_push("stop_e1_state", 4'b0101);
        sb_push("stop_e2_state", 4'b0101);
        for (int i = 0; i < 4; i++) begin
            sb_push("stop_brake_state", 4'b0110);
            sb_push("stop_brake_out", 0);
        end
        sb_push("stop_idle_state", 4'b0100);
        sb_push("stop_idle_out", 0);
        sb_push("stop_stays_idle", 4'b0100);
        for (int i = 0; i < 2; i++) begin
            step(1);
            check(ch_state);
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            check(ch_state);
            check({motor_en[0], motor_in1[0], motor_in2[0]});
            if (i == 0) enable[0] = 1'b0;
            if (i == 1) reverse[0] = 1'b1;
        end
        step(1);
        check(ch_state);
        check({motor_en[0], motor_in1[0], motor_in2[0]});
        step(6);
        check(ch_state);

        // Asynchronous reset while running clears outputs with no clock edge
        reverse[0] = 1'b0;
        enable[0]  = 1'b1;
        sb_push("pre_rst_state", 4'b0101);
        sb_push("pre_rst_in1", 2'b10);
        sb_push("arst_en", 0);
        sb_push("arst_in1", 0);
        sb_push("arst_in2", 0);
        sb_push("arst_state", 0);
        step(3);
        check(ch_state);
        check(motor_in1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check(motor_en);
        check(motor_in1);
        check(motor_in2);
        check(ch_state);

        // After release the synchronisers restart from zero
        step(2);
        resetn = 1'b1;
        sb_push("rel_e1_state", 4'b0000);
        sb_push("rel_e2_state", 4'b0000);
        sb_push("rel_e3_state", 4'b0101);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check(ch_state);
        end

        n_checks++;
        assert (sbq.size() == 0) n_pass++;
        else $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
